ob_phrase_fifo: RTL
===================

// Module: ob_phrase_fifo
// PURPOSE
// - Phrase capture buffer downstream of the object-processor ack pipe. Stores each 64-bit
//   memory phrase on the ack pipe's latch strobe and presents phrases in order to the
//   object fetch/decode logic over a valid/ready handshake.
// - Issues fetch_ok credit to the request sequencer so that no more reads are in flight
//   than the buffer can absorb.
// PARAMETERS
// - DEPTH  4   entries, power of two, 2..16
// - DW     64  phrase width in bits
// PORTS
// - clk        in   1         system clock; all state changes on rising edge
// - reset      in   1         synchronous, active-high
// - req_issue  in   1         one-cycle pulse per read request issued (same strobe that sets latchd)
// - latch      in   1         ack pipe output: data_in valid this cycle
// - data_in    in   DW        memory phrase data
// - out_valid  out  1         out_data holds the oldest phrase
// - out_ready  in   1         consumer accepts out_data this cycle
// - out_data   out  DW        oldest phrase
// - fetch_ok   out  1         credit available; sequencer may issue req_issue
// - count      out  clog2+1   phrases currently stored
// - overflow   out  1         sticky error: latch arrived with no free entry
// - underflow  out  1         sticky error: latch arrived with no request outstanding
// BEHAVIOUR
// - Reset: out_valid=0, count=0, outstanding=0, overflow=0, underflow=0, fetch_ok=1,
//   rd/wr pointers=0. out_data is don't-care while out_valid=0.
// - Push: latch=1 and count<DEPTH (or count==DEPTH with a pop in the same cycle) -> write
//   data_in at wr_ptr, wr_ptr+1 modulo DEPTH.
// - Pop: out_valid & out_ready -> rd_ptr+1 modulo DEPTH.
// - count next = count + push - pop; simultaneous push and pop leaves count unchanged.
// - out_valid = (count!=0), registered. Push into an empty FIFO -> out_valid=1 the next
//   cycle (1-cycle latency).
// - outstanding counter, width clog2(DEPTH)+1: +1 on req_issue, -1 on latch, unchanged
//   when both occur in the same cycle.
// - fetch_ok = (count + outstanding) < DEPTH, combinational from registered state.
//   req_issue while fetch_ok=0 is a protocol violation: counted anyway, saturates at DEPTH.
// - Full + latch without pop: data dropped, pointers/count unchanged, overflow set.
// - latch with outstanding=0 and no req_issue in the same cycle: data still pushed if room,
//   outstanding held at 0, underflow set.
// - overflow and underflow clear only on reset.
// - Reset asserted mid-transfer: all entries and in-flight credits discarded. latch in the
//   cycle reset is high is ignored.
// - out_data must stay stable while out_valid=1 and out_ready=0.
// CONFIGURATION
// - OB_PHRASE_BYPASS_EN defined: when count==0 and latch=1, out_valid=1 and
//   out_data=data_in combinationally in the same cycle.
//   - If out_ready=1 in that cycle: phrase consumed, no write, count stays 0.
//   - Otherwise: normal push.
//   - Latency 0 cycles.
// - OB_PHRASE_BYPASS_EN undefined: out_valid and out_data fully registered, latency 1 cycle.
// TESTING
// - Reset, then 4 req_issue pulses -> fetch_ok=0 after the 4th.
//   4 latches with data 0x11..,0x22..,0x33..,0x44.. -> count=4.
//   Then pop 4 -> data comes out in the same order, fetch_ok=1.
// - Simultaneous push and pop with count=2 -> count stays 2, order preserved.
// - count=4, latch without pop -> overflow=1, data_in dropped, count=4.
//   Next pop returns the oldest entry.
// - latch with outstanding=0 -> underflow=1, phrase stored, outstanding=0.
// - Pointer wrap: 10 push/pop pairs with DEPTH=4 -> all phrases intact, count=0 at end.
// - Reset asserted while count=3, outstanding=1 -> next cycle count=0, out_valid=0, fetch_ok=1.
//   Bypass build: empty FIFO, latch with out_ready=1 -> out_data=data_in in the same cycle,
//   count stays 0.

Source files
------------

// File: rtl/ob_phrase_fifo_if.sv
// Bus between the ob phrase FIFO, the ack pipe / request sequencer and the fetch/decode consumer.
// Parameters DEPTH and DW must match the ob_phrase_fifo instance the bus is bound to.
interface ob_phrase_fifo_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 64
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          req_issue;
   logic          latch;
   logic [DW-1:0] data_in;
   // Handshake: a phrase transfers on every rising edge where out_valid && out_ready;
   // out_data is held stable while out_valid=1 and out_ready=0.
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          fetch_ok;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   modport master (
      output req_issue, latch, data_in, out_ready,
      input  out_valid, out_data, fetch_ok, count, overflow, underflow
   );

   modport slave (
      input  req_issue, latch, data_in, out_ready,
      output out_valid, out_data, fetch_ok, count, overflow, underflow
   );
endinterface

// File: rtl/ob_phrase_fifo.sv
// Phrase capture FIFO behind the object-processor ack pipe, with fetch credit to the sequencer.
// Optional macro OB_PHRASE_BYPASS_EN: zero-latency bypass of an empty FIFO.
module ob_phrase_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 64
) (
   input  logic           clk,
   input  logic           reset,
   ob_phrase_fifo_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] outst_q;
   logic [CW-1:0] outst_d;
   logic          valid_q;
   logic          overflow_q;
   logic          underflow_q;

   logic          empty;
   logic          full;
   logic          store_pop;
   logic          bypass_take;
   logic          push;
   logic [CW:0]   credit_sum;

   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign store_pop = valid_q & bus.out_ready;

`ifdef OB_PHRASE_BYPASS_EN
   logic bypass_hit;
   // An empty FIFO forwards the arriving phrase straight to the consumer.
   assign bypass_hit    = empty & bus.latch & ~reset;
   assign bypass_take   = bypass_hit & bus.out_ready;
   assign bus.out_valid = valid_q | bypass_hit;
   assign bus.out_data  = bypass_hit ? bus.data_in : mem[rd_ptr];
`else
   assign bypass_take   = 1'b0;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = mem[rd_ptr];
`endif

   // A full FIFO still accepts a phrase when the oldest one leaves in the same cycle.
   assign push = bus.latch & ~bypass_take & (~full | store_pop);

   always_comb begin
      count_d = count_q;
      case ({push, store_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Requests beyond DEPTH saturate; a latch with nothing outstanding leaves the counter at 0.
   always_comb begin
      outst_d = outst_q;
      case ({bus.req_issue, bus.latch})
         2'b10:   if (outst_q != DEPTH_C) outst_d = outst_q + CW'(1);
         2'b01:   if (outst_q != '0)      outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         outst_q     <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push)      wr_ptr <= wr_ptr + AW'(1);
         if (store_pop) rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_d;
         outst_q <= outst_d;
         valid_q <= (count_d != '0);
         if (bus.latch & full & ~store_pop)
            overflow_q <= 1'b1;
         if (bus.latch & (outst_q == '0) & ~bus.req_issue)
            underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= bus.data_in;
   end

   assign credit_sum    = {1'b0, count_q} + {1'b0, outst_q};
   assign bus.fetch_ok  = (credit_sum < {1'b0, DEPTH_C});
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule
